// File: rtl/operand_stage_pkg.sv
// rtl/operand_stage_pkg.sv - shared widths, zero-register index and skid-buffer state encoding
package operand_stage_pkg;

    localparam int unsigned PE_XLEN  = 32;
    localparam int unsigned PE_AW    = 5;
    localparam int unsigned ZERO_REG = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

endpackage

// File: rtl/operand_stage_entry.sv
// rtl/operand_stage_entry.sv - one buffered operand slot with capture bypass and write-back snoop
module operand_entry
    import operand_stage_pkg::*;
#(
    parameter int XLEN = PE_XLEN,
    parameter int AW   = PE_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            pop,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            uses_rs2,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            valid,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [AW-1:0]   op_rs1,
    output logic [AW-1:0]   op_rs2
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic            valid_q;
    logic            uses_rs2_q;
    logic [XLEN-1:0] op_a_q;
    logic [XLEN-1:0] op_b_q;
    logic [AW-1:0]   rs1_q;
    logic [AW-1:0]   rs2_q;

    logic            wb_live;
    logic            cap_hit_a;
    logic            cap_hit_b;
    logic [XLEN-1:0] cap_a;
    logic [XLEN-1:0] cap_b;
    logic            snoop_a;
    logic            snoop_b;

    // A write to x0 never lands, so it can neither bypass nor snoop.
    assign wb_live   = wb_en && (wb_addr != ZERO_IDX);

    assign cap_hit_a = wb_live && (wb_addr == rs1_addr);
    assign cap_hit_b = wb_live && (wb_addr == rs2_addr);

    always_comb begin
        cap_a = '0;
        cap_b = '0;
        if (rs1_addr != ZERO_IDX) begin
            cap_a = cap_hit_a ? wb_data : rs1_data;
        end
        if (uses_rs2 && (rs2_addr != ZERO_IDX)) begin
            cap_b = cap_hit_b ? wb_data : rs2_data;
        end
    end

    // Stored indices are nonzero whenever a snoop can match, so x0 stays 0.
    assign snoop_a = valid_q && !pop && wb_live && (wb_addr == rs1_q);
    assign snoop_b = valid_q && !pop && wb_live && uses_rs2_q && (wb_addr == rs2_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            uses_rs2_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else if (load) begin
            valid_q    <= 1'b1;
            uses_rs2_q <= uses_rs2;
            op_a_q     <= cap_a;
            op_b_q     <= cap_b;
            rs1_q      <= rs1_addr;
            rs2_q      <= rs2_addr;
        end else if (pop) begin
            valid_q    <= 1'b0;
        end else begin
            if (snoop_a) begin
                op_a_q <= wb_data;
            end
            if (snoop_b) begin
                op_b_q <= wb_data;
            end
        end
    end

    assign valid  = valid_q;
    assign op_a   = op_a_q;
    assign op_b   = op_b_q;
    assign op_rs1 = rs1_q;
    assign op_rs2 = rs2_q;

endmodule

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - two-entry in-order skid buffer delivering bypassed operand pairs to execute
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int XLEN = PE_XLEN,
    parameter int AW   = PE_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            uses_rs2,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [AW-1:0]   op_rs1,
    output logic [AW-1:0]   op_rs2
);

    stage_state_t state_q;
    stage_state_t state_d;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         head_q;
    logic         tail_q;

    logic         push;
    logic         pop;
    logic [1:0]   load;
    logic [1:0]   pop_slot;

    logic [1:0]      e_valid;
    logic [XLEN-1:0] e_op_a   [2];
    logic [XLEN-1:0] e_op_b   [2];
    logic [AW-1:0]   e_op_rs1 [2];
    logic [AW-1:0]   e_op_rs2 [2];

    // in_ready and out_valid are flops of the next state, so out_ready never reaches in_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
            if (pop) begin
                head_q <= ~head_q;
            end
            if (push) begin
                tail_q <= ~tail_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (push) state_d = ST_ONE;
            ST_ONE: begin
                if (push && !pop) begin
                    state_d = ST_TWO;
                end else if (pop && !push) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO:   if (pop) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        push        = in_valid && in_ready_q;
        pop         = out_valid_q && out_ready;
        load        = '0;
        pop_slot    = '0;
        load[tail_q]     = push;
        pop_slot[head_q] = pop;
        in_ready    = in_ready_q;
        out_valid   = out_valid_q;
        op_a        = e_op_a[head_q];
        op_b        = e_op_b[head_q];
        op_rs1      = e_op_rs1[head_q];
        op_rs2      = e_op_rs2[head_q];
    end

    for (genvar g = 0; g < 2; g++) begin : g_entry
        operand_entry #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[g]),
            .pop      (pop_slot[g]),
            .rs1_addr (rs1_addr),
            .rs2_addr (rs2_addr),
            .rs1_data (rs1_data),
            .rs2_data (rs2_data),
            .uses_rs2 (uses_rs2),
            .wb_en    (wb_en),
            .wb_addr  (wb_addr),
            .wb_data  (wb_data),
            .valid    (e_valid[g]),
            .op_a     (e_op_a[g]),
            .op_b     (e_op_b[g]),
            .op_rs1   (e_op_rs1[g]),
            .op_rs2   (e_op_rs2[g])
        );
    end

    logic unused_valid;
    assign unused_valid = ^e_valid;

endmodule
